// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the MEM stage (port 0) and a
// secondary master (port 1). One access at a time: the winner's op, address and
// write data are latched in IDLE and held on the controller lines for the whole
// BUSY phase; DONE returns a one-cycle ack with the captured read data.
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on contention.
// Without it port 0 always wins contention (last_grant is still tracked).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight, enables low, requests sampled every edge
// BUSY  | enables driven from latched op, waiting for mem_ready
// DONE  | enables low, ack to owner for one cycle, requests ignored

module sram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              grant,
   output logic              busy,
   output logic              mem_w_en,
   output logic              mem_r_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              grant_q;
   logic              last_grant;
   logic              win;
   logic              start;

   // Winner selection among current requesters.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
`ifdef SRAM_ARB_RR_EN
         win = ~last_grant;
`else
         // Fixed priority: port 0 wins; last_grant is history only here.
         win = last_grant & 1'b0;
`endif
      end else if (req1) begin
         win = 1'b1;
      end
   end

   assign start = (state == IDLE) && (req0 || req1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs. mem_ready only matters in BUSY:
   // the controller reports ready whenever it is idle.
   always_comb begin
      state_nxt = state;
      mem_w_en  = 1'b0;
      mem_r_en  = 1'b0;
      busy      = 1'b0;
      grant     = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy     = 1'b1;
            grant    = grant_q;
            mem_w_en = lat_wr;
            mem_r_en = ~lat_wr;
            if (mem_ready) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            grant     = grant_q;
            ack0      = ~grant_q;
            ack1      = grant_q;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request latch on IDLE->BUSY and read-data capture on the ready edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_wr     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         grant_q    <= 1'b0;
         last_grant <= 1'b1;
         rdata      <= '0;
      end else begin
         if (start) begin
            lat_wr     <= win ? wr1    : wr0;
            lat_addr   <= win ? addr1  : addr0;
            lat_wdata  <= win ? wdata1 : wdata0;
            grant_q    <= win;
            last_grant <= win;
         end
         if ((state == BUSY) && mem_ready && !lat_wr) begin
            rdata <= mem_rdata;
         end
      end
   end

   // Controller lines come only from the latch so requester inputs may move.
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM controller model that
// completes an access on the 6th enabled cycle and reports ready when idle.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic        ack0, ack1, grant, busy, mem_w_en, mem_r_en, mem_ready;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .grant(grant), .busy(busy),
      .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Controller model: 64-word array indexed by addr[7:2], preloaded on reset.
   logic [31:0] sram [0:63];
   logic [2:0]  sc;
   wire         en = mem_w_en | mem_r_en;
   assign mem_ready = !en || (sc == 3'd5);
   assign mem_rdata = sram[mem_addr[7:2]];

   always @(posedge clk) begin
      if (rst) begin
         sc <= 3'd0;
         for (int i = 0; i < 64; i++) sram[i] <= 32'h0;
         sram[0] <= 32'hDEADBEEF;
      end else begin
         if (en && sc != 3'd5) sc <= sc + 3'd1;
         else sc <= 3'd0;
         if (mem_w_en && sc == 3'd5) sram[mem_addr[7:2]] <= mem_wdata;
      end
   end

   typedef struct {
      bit          port;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } txn_t;

   txn_t tbl [6];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit port, input bit rq, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 1'b0) begin
         req0 = rq; wr0 = wr; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = rq; wr1 = wr; addr1 = addr; wdata1 = wdata;
      end
   endtask

   // One access from IDLE: BUSY cycles 1-6, DONE cycle 7, IDLE cycle 8.
   task automatic do_txn(input bit port, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input string tag);
      drive(port, 1'b1, wr, addr, wdata);
      for (int c = 1; c <= 7; c++) begin
         tick;
         if (c <= 6) begin
            chk({tag, " busy"}, busy, 1);
            chk({tag, " grant"}, grant, port);
            chk({tag, " r_en"}, mem_r_en, !wr);
            chk({tag, " w_en"}, mem_w_en, wr);
            chk({tag, " mem_addr"}, mem_addr, addr);
            if (wr) chk({tag, " mem_wdata"}, mem_wdata, wdata);
            chk({tag, " early ack0"}, ack0, 0);
            chk({tag, " early ack1"}, ack1, 0);
         end else begin
            chk({tag, " done en"}, en, 0);
            chk({tag, " done ack0"}, ack0, port == 1'b0);
            chk({tag, " done ack1"}, ack1, port == 1'b1);
            chk({tag, " done grant"}, grant, port);
            chk({tag, " rdata"}, rdata, exp_rd);
         end
      end
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      chk({tag, " idle busy"}, busy, 0);
      chk({tag, " idle grant"}, grant, 0);
      chk({tag, " idle ack"}, {ack1, ack0}, 0);
      chk({tag, " rdata hold"}, rdata, exp_rd);
   endtask

   initial begin
      tbl[0] = '{port: 1'b0, wr: 1'b0, addr: 32'h400, wdata: 32'h0,         exp_rdata: 32'hDEADBEEF};
      tbl[1] = '{port: 1'b1, wr: 1'b1, addr: 32'h408, wdata: 32'h12345678,  exp_rdata: 32'hDEADBEEF};
      tbl[2] = '{port: 1'b0, wr: 1'b0, addr: 32'h408, wdata: 32'h0,         exp_rdata: 32'h12345678};
      tbl[3] = '{port: 1'b1, wr: 1'b0, addr: 32'h400, wdata: 32'h0,         exp_rdata: 32'hDEADBEEF};
      tbl[4] = '{port: 1'b0, wr: 1'b1, addr: 32'h40C, wdata: 32'hA5A50F0F,  exp_rdata: 32'hDEADBEEF};
      tbl[5] = '{port: 1'b1, wr: 1'b0, addr: 32'h40C, wdata: 32'h0,         exp_rdata: 32'hA5A50F0F};

      // Reset state
      rst = 1'b1;
      tick;
      tick;
      chk("rst busy", busy, 0);
      chk("rst grant", grant, 0);
      chk("rst acks", {ack1, ack0}, 0);
      chk("rst enables", {mem_w_en, mem_r_en}, 0);
      chk("rst rdata", rdata, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      rst = 1'b0;
      tick;

      // Table of single accesses
      foreach (tbl[i])
         do_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
                $sformatf("txn%0d", i));

      // Requester inputs move during BUSY; controller lines must not
      drive(1'b0, 1'b1, 1'b1, 32'h410, 32'hCAFEF00D);
      for (int c = 1; c <= 6; c++) begin
         tick;
         chk("stab mem_addr", mem_addr, 32'h410);
         chk("stab mem_wdata", mem_wdata, 32'hCAFEF00D);
         chk("stab w_en", mem_w_en, 1);
         addr0  = 32'h1000 + 32'(c * 4);
         wdata0 = $urandom;
      end
      tick;
      chk("stab ack0", ack0, 1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      do_txn(1'b1, 1'b0, 32'h410, 32'h0, 32'hCAFEF00D, "stab readback");

      // mem_ready high while idle with no requests
      for (int c = 0; c < 5; c++) begin
         tick;
         chk("rdy busy", busy, 0);
         chk("rdy enables", {mem_w_en, mem_r_en}, 0);
         chk("rdy acks", {ack1, ack0}, 0);
      end

      // Reset during BUSY cycle 3
      drive(1'b0, 1'b1, 1'b0, 32'h408, 32'h0);
      tick;
      tick;
      tick;
      chk("mid busy before rst", busy, 1);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      chk("mid busy", busy, 0);
      chk("mid enables", {mem_w_en, mem_r_en}, 0);
      chk("mid acks", {ack1, ack0}, 0);
      chk("mid rdata", rdata, 0);
      chk("mid grant", grant, 0);
      chk("mid mem_addr", mem_addr, 0);
      rst = 1'b0;
      tick;
      chk("mid post acks", {ack1, ack0}, 0);
      do_txn(1'b0, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, "mid later");

      // Contention from a fresh reset (last_grant = 1)
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h400; wdata0 = 32'h0;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h408; wdata1 = 32'h0;
      for (int cyc = 1; cyc <= 31; cyc++) begin
         int  k;
         bit  w;
         bit  in_acc;
         tick;
         k      = cyc / 8;
         w      = (k < 3) ? (RR ? k[0] : 1'b0) : 1'b1;
         in_acc = (cyc % 8) != 0;
         chk($sformatf("cont busy c%0d", cyc), busy, in_acc);
         chk($sformatf("cont grant c%0d", cyc), grant, in_acc ? w : 1'b0);
         chk($sformatf("cont ack0 c%0d", cyc), ack0, (cyc % 8 == 7) && !w);
         chk($sformatf("cont ack1 c%0d", cyc), ack1, (cyc % 8 == 7) && w);
         if (cyc == 23) req0 = 1'b0;
         if (cyc == 31) req1 = 1'b0;
      end
      tick;
      chk("cont end busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer placed in front of the SRAM controller. It lets the pipeline MEM stage (port 0) and a secondary master (port 1, e.g. a fetch or DMA unit) share the single SRAM controller. It serialises their read and write requests, holds the controller's enable, address and data lines stable for the whole access, and returns a one-cycle acknowledge with the captured read data.

## Interface
- ADDR_W, 32, address width, passed through unchanged
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0  in  1  port 0 request, level; held until ack0
- wr0  in  1  port 0 operation: 1 = write, 0 = read; valid while req0
- addr0  in  ADDR_W  port 0 byte address
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 completion pulse, one cycle
- req1, wr1, addr1, wdata1, ack1: same as port 0, for port 1
- rdata  out  DATA_W  read data of the last completed read; valid while ack0/ack1 high
- grant  out  1  owner index; valid in BUSY/DONE, 0 in IDLE
- busy  out  1  high in BUSY and DONE
- mem_w_en  out  1  to controller MEM_W_EN
- mem_r_en  out  1  to controller MEM_R_EN
- mem_addr  out  ADDR_W  to controller address
- mem_wdata  out  DATA_W  to controller writeData
- mem_ready  in  1  controller ready
- mem_rdata  in  DATA_W  controller readData

## Operation
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: all outputs 0, rdata 0, latched op/addr/wdata 0, last_grant 1.
- IDLE:
  - mem_w_en = mem_r_en = 0.
  - If req0 or req1 is high at the clock edge, select a winner and latch its wr/addr/wdata and the grant index; next state BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Drive mem_w_en = latched wr and mem_r_en = ~latched wr.
  - Drive mem_addr and mem_wdata from the latched values, so requester inputs may change freely.
  - At an edge with mem_ready = 1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
  - mem_ready is ignored in IDLE and DONE. The controller reports ready when idle, so it must never be treated as completion there.
- DONE:
  - Enables 0, ack[grant] = 1 for exactly this cycle.
  - Requests are ignored in this cycle; next state IDLE.
  - The requester must drop or replace its request on the edge that ends DONE.
- Default priority is fixed: port 0 wins when both request.
- last_grant is updated to the winner on every IDLE→BUSY transition.
- A request is never cancelled: req dropping in BUSY does not abort the access.
- Reset asserted in any state forces IDLE and the reset values on the next edge. The controller shares rst, so no partial access survives.

## Timing
- The controller completes one access 6 cycles after its enables rise (counter 0..5).
- Request seen in IDLE at edge E0:
  - BUSY for cycles 1–6, mem_ready high in cycle 6.
  - DONE in cycle 7 with ack high.
  - IDLE in cycle 8.
- Request-to-ack latency: 7 cycles. Back-to-back throughput: one access per 8 cycles.
- Enables drop in the cycle after the ready edge, so the controller counter restarts from 0 for the next access.
- The ack is registered; rdata is stable from the DONE cycle until the next completing read.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - When both ports request in IDLE, grant the port ≠ last_grant.
  - A single requester always wins.
  - last_grant resets to 1, so port 0 wins the first contention.
- SRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins contention. last_grant is still kept but unused.

## Test plan
- Single read: port 0 reads addr 0x400 and the SRAM word holds 0xDEADBEEF → mem_r_en high for cycles 1–6, ack0 in cycle 7, rdata = 0xDEADBEEF, ack1 never asserts.
- Single write: port 1 writes 0x12345678 to 0x408 → mem_w_en high for 6 cycles with mem_addr = 0x408 and mem_wdata = 0x12345678; ack1 in cycle 7; rdata unchanged.
- Contention: req0 and req1 asserted in the same cycle, both held →
  - fixed mode: three port 0 accesses before any port 1 access;
  - SRAM_ARB_RR_EN: grants alternate 0,1,0,1, acks 8 cycles apart.
- Input stability: change addr0/wdata0 every cycle during BUSY → mem_addr and mem_wdata stay at the values latched in IDLE.
- Ready ignored: mem_ready held 1 with no requests → FSM stays IDLE, no ack, enables 0.
- Reset mid-access: assert rst in BUSY cycle 3 → next cycle IDLE, enables 0, no ack, rdata = 0. A later request completes normally in 7 cycles.
